// File: rtl/icache_refill_engine.sv
// Instruction-cache line refill over an Avalon-MM read burst, critical beat first with wrap.
// Early-instruction bypass from the refill buffer is built only when ICACHE_REFILL_BYPASS_EN is defined.
module icache_refill_engine #(
    parameter int unsigned BUS_W       = 64,
    parameter int unsigned OFFSET_BITS = 6,
    parameter int unsigned INDEX_BITS  = 6,
    parameter int unsigned TAG_BITS    = 32 - INDEX_BITS - OFFSET_BITS,
    localparam int unsigned LINE_W     = 8 * (2 ** OFFSET_BITS),
    localparam int unsigned BEATS      = LINE_W / BUS_W,
    localparam int unsigned BEAT_BITS  = $clog2(BEATS),
    localparam int unsigned BYTE_BITS  = $clog2(BUS_W / 8),
    localparam int unsigned BURST_W    = BEAT_BITS + 1
) (
    input  logic                   clock,
    input  logic                   reset,
    output logic [31:0]            avm_address,
    output logic                   avm_read,
    output logic [BURST_W-1:0]     avm_burstcount,
    input  logic [BUS_W-1:0]       avm_readdata,
    input  logic                   avm_waitrequest,
    input  logic                   avm_readdatavalid,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [TAG_BITS-1:0]    req_tag,
    input  logic [INDEX_BITS-1:0]  req_index,
    input  logic [OFFSET_BITS-1:0] req_offset,
    input  logic                   abort,
    output logic                   fill_valid,
    output logic [TAG_BITS-1:0]    fill_tag,
    output logic [INDEX_BITS-1:0]  fill_index,
    output logic [LINE_W-1:0]      fill_line,
    output logic                   busy,
    input  logic [TAG_BITS-1:0]    lookup_tag,
    input  logic [INDEX_BITS-1:0]  lookup_index,
    input  logic [OFFSET_BITS-1:0] lookup_offset,
    output logic                   bypass_hit,
    output logic [31:0]            bypass_instruction
);

    typedef enum logic [1:0] {StIdle, StReq, StData, StDone} state_e;

    state_e                  state_q;
    logic [TAG_BITS-1:0]     tag_q;
    logic [INDEX_BITS-1:0]   index_q;
    logic [BEAT_BITS-1:0]    crit_q;
    logic [BEAT_BITS-1:0]    wr_ptr_q;
    logic [BEAT_BITS-1:0]    count_q;
    logic [BEATS-1:0]        mask_q;
    logic                    aborted_q;
    logic                    avm_read_q;
    logic                    fill_valid_q;
    logic [LINE_W-1:0]       line_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            tag_q        <= '0;
            index_q      <= '0;
            crit_q       <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            mask_q       <= '0;
            aborted_q    <= 1'b0;
            avm_read_q   <= 1'b0;
            fill_valid_q <= 1'b0;
        end else begin
            fill_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        tag_q      <= req_tag;
                        index_q    <= req_index;
                        crit_q     <= req_offset[OFFSET_BITS-1:BYTE_BITS];
                        wr_ptr_q   <= req_offset[OFFSET_BITS-1:BYTE_BITS];
                        count_q    <= '0;
                        mask_q     <= '0;
                        aborted_q  <= 1'b0;
                        avm_read_q <= 1'b1;
                        state_q    <= StReq;
                    end
                end
                StReq: begin
                    if (abort) aborted_q <= 1'b1;
                    if (!avm_waitrequest) begin
                        avm_read_q <= 1'b0;
                        state_q    <= StData;
                    end
                end
                StData: begin
                    if (abort) aborted_q <= 1'b1;
                    // Burst cannot be cancelled on Avalon, so every beat is drained even after abort.
                    if (avm_readdatavalid) begin
                        mask_q[wr_ptr_q] <= 1'b1;
                        wr_ptr_q         <= wr_ptr_q + 1'b1;
                        count_q          <= count_q + 1'b1;
                        if (count_q == BEAT_BITS'(BEATS - 1)) state_q <= StDone;
                    end
                end
                StDone: begin
                    fill_valid_q <= !aborted_q && !abort;
                    if (abort) aborted_q <= 1'b1;
                    state_q      <= StIdle;
                end
            endcase
        end
    end

    // Line buffer intentionally has no reset.
    always_ff @(posedge clock) begin
        if (state_q == StData && avm_readdatavalid) begin
            line_q[BUS_W*wr_ptr_q +: BUS_W] <= avm_readdata;
        end
    end

    assign avm_address    = {tag_q, index_q, crit_q, {BYTE_BITS{1'b0}}};
    assign avm_read       = avm_read_q;
    assign avm_burstcount = BURST_W'(BEATS);
    assign req_ready      = (state_q == StIdle);
    assign busy           = (state_q != StIdle);
    assign fill_valid     = fill_valid_q;
    assign fill_tag       = tag_q;
    assign fill_index     = index_q;
    assign fill_line      = line_q;

`ifdef ICACHE_REFILL_BYPASS_EN
    logic [BEAT_BITS-1:0] lookup_beat;
    logic [1:0]           unused_lookup;

    assign lookup_beat        = lookup_offset[OFFSET_BITS-1:BYTE_BITS];
    assign bypass_hit         = busy && !aborted_q && (lookup_tag == tag_q) &&
                                (lookup_index == index_q) && mask_q[lookup_beat];
    assign bypass_instruction = line_q[32*lookup_offset[OFFSET_BITS-1:2] +: 32];
    assign unused_lookup      = lookup_offset[1:0];
`else
    logic unused_lookup;

    assign bypass_hit         = 1'b0;
    assign bypass_instruction = 32'h0;
    assign unused_lookup      = ^{lookup_tag, lookup_index, lookup_offset, mask_q};
`endif

    logic [BYTE_BITS-1:0] unused_req_offset;
    assign unused_req_offset = req_offset[BYTE_BITS-1:0];

endmodule
